// File: rtl/vga_timing_gen.sv
// Parameterised VGA raster timing generator with a pixel-request port and a matched output delay line.
// Define VGA_TESTPAT_EN to add the testpat_en input and an 8-bar colour test pattern.
module vga_timing_gen #(
   parameter int CW       = 4,
   parameter int H_SYNC   = 152,
   parameter int H_BP     = 232,
   parameter int H_ACTIVE = 1440,
   parameter int H_FP     = 80,
   parameter int V_SYNC   = 3,
   parameter int V_BP     = 28,
   parameter int V_ACTIVE = 900,
   parameter int V_FP     = 1,
   parameter int H_POL    = 0,
   parameter int V_POL    = 0,
   parameter int PIPE_LAT = 0,
   parameter int XW       = 11,
   parameter int YW       = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] r_in,
   input  logic [CW-1:0] g_in,
   input  logic [CW-1:0] b_in,
   output logic [XW-1:0] curr_x,
   output logic [YW-1:0] curr_y,
   output logic          req,
   output logic [CW-1:0] pix_r,
   output logic [CW-1:0] pix_g,
   output logic [CW-1:0] pix_b,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic          line_start,
   output logic          frame_start
`ifdef VGA_TESTPAT_EN
   ,
   input  logic          testpat_en
`endif
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
   localparam logic [XW-1:0] H_SYNC_END = XW'(H_SYNC);
   localparam logic [XW-1:0] H_ACT_BEG  = XW'(H_SYNC + H_BP);
   localparam logic [XW-1:0] H_ACT_END  = XW'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
   localparam logic [YW-1:0] V_SYNC_END = YW'(V_SYNC);
   localparam logic [YW-1:0] V_ACT_BEG  = YW'(V_SYNC + V_BP);
   localparam logic [YW-1:0] V_ACT_END  = YW'(V_SYNC + V_BP + V_ACTIVE);

   localparam logic HP = (H_POL != 0);
   localparam logic VP = (V_POL != 0);

   // Bit positions inside each delay-line stage
   localparam int B_HS = 4;
   localparam int B_VS = 3;
   localparam int B_DE = 2;
   localparam int B_LS = 1;
   localparam int B_FS = 0;

   logic [XW-1:0] r_hcount;
   logic [YW-1:0] r_vcount;
   logic          w_h_act;
   logic          w_v_act;
   logic          w_active;
   logic [4:0]    w_ctl;
   logic [4:0]    r_dly [PIPE_LAT+1];
   logic [4:0]    w_out;
   logic          w_de_tap;
   logic [CW-1:0] w_col_r;
   logic [CW-1:0] w_col_g;
   logic [CW-1:0] w_col_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hcount <= '0;
         r_vcount <= '0;
      end else if (r_hcount == H_LAST) begin
         r_hcount <= '0;
         r_vcount <= (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
      end else begin
         r_hcount <= r_hcount + 1'b1;
      end
   end

   assign w_h_act  = (r_hcount >= H_ACT_BEG) && (r_hcount < H_ACT_END);
   assign w_v_act  = (r_vcount >= V_ACT_BEG) && (r_vcount < V_ACT_END);
   assign w_active = w_h_act && w_v_act;

   assign req    = w_active;
   assign curr_x = w_active ? (r_hcount - H_ACT_BEG) : '0;
   assign curr_y = w_active ? (r_vcount - V_ACT_BEG) : '0;

   assign w_ctl = {r_hcount < H_SYNC_END,
                   r_vcount < V_SYNC_END,
                   w_active,
                   r_hcount == '0,
                   (r_hcount == '0) && (r_vcount == '0)};

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= PIPE_LAT; i++) r_dly[i] <= '0;
      end else begin
         r_dly[0] <= w_ctl;
         for (int i = 1; i <= PIPE_LAT; i++) r_dly[i] <= r_dly[i-1];
      end
   end

   // The colour register samples alongside the last delay stage, so it is gated by the stage before it
   generate
      if (PIPE_LAT == 0) begin : g_tap0
         assign w_de_tap = w_active;
      end else begin : g_tapn
         assign w_de_tap = r_dly[PIPE_LAT-1][B_DE];
      end
   endgenerate

`ifdef VGA_TESTPAT_EN
   logic [XW-1:0] w_x_tap;
   logic [XW+2:0] w_scaled;
   logic [2:0]    w_bar;

   generate
      if (PIPE_LAT == 0) begin : g_x0
         assign w_x_tap = curr_x;
      end else begin : g_xn
         logic [XW-1:0] r_xdly [PIPE_LAT];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < PIPE_LAT; i++) r_xdly[i] <= '0;
            end else begin
               r_xdly[0] <= curr_x;
               for (int i = 1; i < PIPE_LAT; i++) r_xdly[i] <= r_xdly[i-1];
            end
         end
         assign w_x_tap = r_xdly[PIPE_LAT-1];
      end
   endgenerate

   // Bar index = floor(8*x / H_ACTIVE), giving eight equal-width columns
   assign w_scaled = {w_x_tap, 3'b000};
   assign w_bar    = 3'(w_scaled / (XW+3)'(H_ACTIVE));

   assign w_col_r = testpat_en ? {CW{w_bar[2]}} : r_in;
   assign w_col_g = testpat_en ? {CW{w_bar[1]}} : g_in;
   assign w_col_b = testpat_en ? {CW{w_bar[0]}} : b_in;
`else
   assign w_col_r = r_in;
   assign w_col_g = g_in;
   assign w_col_b = b_in;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_r <= '0;
         pix_g <= '0;
         pix_b <= '0;
      end else if (w_de_tap) begin
         pix_r <= w_col_r;
         pix_g <= w_col_g;
         pix_b <= w_col_b;
      end else begin
         pix_r <= '0;
         pix_g <= '0;
         pix_b <= '0;
      end
   end

   assign w_out       = r_dly[PIPE_LAT];
   assign hsync       = w_out[B_HS] ? HP : ~HP;
   assign vsync       = w_out[B_VS] ? VP : ~VP;
   assign de          = w_out[B_DE];
   assign line_start  = w_out[B_LS];
   assign frame_start = w_out[B_FS];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two small-raster instances (PIPE_LAT 0 and 3) checked every cycle
// against an arithmetic raster model, plus hand-computed frame statistics.
module tb_vga_timing_gen;

   localparam int HS = 4, HBP = 3, HACT = 16, HFP = 2, HT = HS + HBP + HACT + HFP;  // 25
   localparam int VS = 2, VBP = 2, VACT = 5,  VFP = 1, VT = VS + VBP + VACT + VFP;  // 10
   localparam int XW = 6, YW = 5, CW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [XW-1:0] cx0, cx3;
   logic [YW-1:0] cy0, cy3;
   logic          req0, req3;
   logic [CW-1:0] ri0, gi0, bi0, ri3, gi3, bi3;
   logic [CW-1:0] pr0, pg0, pb0, pr3, pg3, pb3;
   logic          hs0, vs0, de0, ls0, fs0;
   logic          hs3, vs3, de3, ls3, fs3;
`ifdef VGA_TESTPAT_EN
   logic          tp = 1'b0;
`endif

   int errors = 0;
   int checks = 0;

   // Colour source: r = x, g = y, b = x^y (low nibbles); fed directly (lat 0) or via 3 registers (lat 3)
   assign ri0 = cx0[3:0];
   assign gi0 = cy0[3:0];
   assign bi0 = cx0[3:0] ^ cy0[3:0];

   logic [3:0] p_r [3];
   logic [3:0] p_g [3];
   logic [3:0] p_b [3];
   always @(posedge clk) begin
      p_r[0] <= cx3[3:0];
      p_g[0] <= cy3[3:0];
      p_b[0] <= cx3[3:0] ^ cy3[3:0];
      for (int i = 1; i < 3; i++) begin
         p_r[i] <= p_r[i-1];
         p_g[i] <= p_g[i-1];
         p_b[i] <= p_b[i-1];
      end
   end
   assign ri3 = p_r[2];
   assign gi3 = p_g[2];
   assign bi3 = p_b[2];

   vga_timing_gen #(
      .CW(CW), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HACT), .H_FP(HFP),
      .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VACT), .V_FP(VFP),
      .H_POL(0), .V_POL(0), .PIPE_LAT(0), .XW(XW), .YW(YW)
   ) u_l0 (
      .clk(clk), .rst(rst), .r_in(ri0), .g_in(gi0), .b_in(bi0),
      .curr_x(cx0), .curr_y(cy0), .req(req0),
      .pix_r(pr0), .pix_g(pg0), .pix_b(pb0),
      .hsync(hs0), .vsync(vs0), .de(de0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TESTPAT_EN
      , .testpat_en(tp)
`endif
   );

   vga_timing_gen #(
      .CW(CW), .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HACT), .H_FP(HFP),
      .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VACT), .V_FP(VFP),
      .H_POL(1), .V_POL(1), .PIPE_LAT(3), .XW(XW), .YW(YW)
   ) u_l3 (
      .clk(clk), .rst(rst), .r_in(ri3), .g_in(gi3), .b_in(bi3),
      .curr_x(cx3), .curr_y(cy3), .req(req3),
      .pix_r(pr3), .pix_g(pg3), .pix_b(pb3),
      .hsync(hs3), .vsync(vs3), .de(de3), .line_start(ls3), .frame_start(fs3)
`ifdef VGA_TESTPAT_EN
      , .testpat_en(tp)
`endif
   );

   task automatic chk(input string name, input int n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, n, act, exp);
      end
   endtask

   // Raster position n cycles after reset release (n<0: held in reset, counters at 0,0)
   task automatic ctr_model(input int n, output int rq, output int x, output int y);
      int hc, vc;
      hc = (n < 0) ? 0 : n % HT;
      vc = (n < 0) ? 0 : (n / HT) % VT;
      rq = (hc >= HS + HBP && hc < HS + HBP + HACT && vc >= VS + VBP && vc < VS + VBP + VACT) ? 1 : 0;
      x  = rq ? hc - HS - HBP : 0;
      y  = rq ? vc - VS - VBP : 0;
   endtask

   task automatic out_model(input int lat, input int hpol, input int vpol, input int n,
                            output int hs, output int vs, output int d, output int ls, output int fs,
                            output int r, output int g, output int b);
      int s, hc, vc, rq, x, y;
      s = n - lat - 1;
      if (n < 0 || s < 0) begin
         hs = 1 - hpol; vs = 1 - vpol; d = 0; ls = 0; fs = 0; r = 0; g = 0; b = 0;
      end else begin
         hc = s % HT;
         vc = (s / HT) % VT;
         ctr_model(s, rq, x, y);
         hs = (hc < HS) ? hpol : 1 - hpol;
         vs = (vc < VS) ? vpol : 1 - vpol;
         d  = rq;
         ls = (hc == 0) ? 1 : 0;
         fs = (hc == 0 && vc == 0) ? 1 : 0;
         r  = rq ? (x & 15) : 0;
         g  = rq ? (y & 15) : 0;
         b  = rq ? ((x ^ y) & 15) : 0;
      end
   endtask

   task automatic check_all(input int n);
      int rq, x, y, hs, vs, d, ls, fs, r, g, b;
      ctr_model(n, rq, x, y);
      chk("l0_req", n, int'(req0), rq);
      chk("l0_curr_x", n, int'(cx0), x);
      chk("l0_curr_y", n, int'(cy0), y);
      chk("l3_req", n, int'(req3), rq);
      chk("l3_curr_x", n, int'(cx3), x);
      chk("l3_curr_y", n, int'(cy3), y);
      out_model(0, 0, 0, n, hs, vs, d, ls, fs, r, g, b);
      chk("l0_hsync", n, int'(hs0), hs);
      chk("l0_vsync", n, int'(vs0), vs);
      chk("l0_de", n, int'(de0), d);
      chk("l0_line_start", n, int'(ls0), ls);
      chk("l0_frame_start", n, int'(fs0), fs);
      chk("l0_pix_r", n, int'(pr0), r);
      chk("l0_pix_g", n, int'(pg0), g);
      chk("l0_pix_b", n, int'(pb0), b);
      out_model(3, 1, 1, n, hs, vs, d, ls, fs, r, g, b);
      chk("l3_hsync", n, int'(hs3), hs);
      chk("l3_vsync", n, int'(vs3), vs);
      chk("l3_de", n, int'(de3), d);
      chk("l3_line_start", n, int'(ls3), ls);
      chk("l3_frame_start", n, int'(fs3), fs);
      chk("l3_pix_r", n, int'(pr3), r);
      chk("l3_pix_g", n, int'(pg3), g);
      chk("l3_pix_b", n, int'(pb3), b);
   endtask

   initial begin
      int n_hs0 = 0, n_vs0 = 0, n_de0 = 0, n_fs0 = 0, n_ls0 = 0, n_hs3 = 0;
      int first_req = -1, first_de3 = -1, first_pix = -1, last_pix = -1;
      logic prev_de0 = 1'b0;
      logic [3:0] prev_pr0 = '0;

      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_all(-1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int n = 0; n <= 637; n++) begin
         @(negedge clk);
         check_all(n);
         if (req0 && first_req < 0) first_req = n;
         if (de3 && first_de3 < 0) first_de3 = n;
         if (n >= 1 && n <= HT * VT) begin
            if (!hs0) n_hs0++;
            if (!vs0) n_vs0++;
            if (de0)  n_de0++;
            if (fs0)  n_fs0++;
            if (ls0)  n_ls0++;
            if (hs3)  n_hs3++;
            if (de0 && !prev_de0 && first_pix < 0) first_pix = int'(pr0);
            if (!de0 && prev_de0 && last_pix < 0) last_pix = int'(prev_pr0);
         end
         prev_de0 = de0;
         prev_pr0 = pr0;
         if (n == 1) chk("lit_l0_first_frame_start", n, int'(fs0), 1);
         if (n == 4) chk("lit_l3_first_frame_start", n, int'(fs3), 1);
         if (n == 250) chk("lit_l0_no_ls_before_wrap", n, int'(ls0), 0);
         if (n == 251) begin
            chk("lit_wrap_line_start", n, int'(ls0), 1);
            chk("lit_wrap_frame_start", n, int'(fs0), 1);
            chk("lit_hsync_low_per_frame", n, n_hs0, 40);
            chk("lit_vsync_low_per_frame", n, n_vs0, 50);
            chk("lit_de_per_frame", n, n_de0, 80);
            chk("lit_frame_starts", n, n_fs0, 1);
            chk("lit_line_starts", n, n_ls0, 10);
            chk("lit_l3_hsync_high", n, n_hs3, 40);
            chk("lit_first_de_pix_r", n, first_pix, 0);
            chk("lit_last_de_pix_r", n, last_pix, 15);
            chk("lit_first_req_cycle", n, first_req, 107);
            chk("lit_l3_de_after_req", n, first_de3 - first_req, 4);
         end
         if (n < 637) @(posedge clk);
      end

      // Mid-frame reset at line 5, column 12 (active area)
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;

      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         check_all(n);
         if (n == 0) begin
            chk("lit_rst_de", n, int'(de0), 0);
            chk("lit_rst_hsync", n, int'(hs0), 1);
            chk("lit_rst_l3_hsync", n, int'(hs3), 0);
            chk("lit_rst_pix_r", n, int'(pr0), 0);
            chk("lit_rst_l3_de", n, int'(de3), 0);
         end
         if (n == 1) chk("lit_rst_l0_frame_start", n, int'(fs0), 1);
         if (n == 4) chk("lit_rst_l3_frame_start", n, int'(fs3), 1);
         @(posedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- CW, 4: colour channel width.
- H_SYNC, 152: horizontal sync pulse length in pixels.
- H_BP, 232: horizontal back porch in pixels.
- H_ACTIVE, 1440: visible pixels per line.
- H_FP, 80: horizontal front porch in pixels.
- V_SYNC, 3: vertical sync pulse length in lines.
- V_BP, 28: vertical back porch in lines.
- V_ACTIVE, 900: visible lines per frame.
- V_FP, 1: vertical front porch in lines.
- H_POL, 0: hsync asserted level.
- V_POL, 0: vsync asserted level.
- PIPE_LAT, 0 (range 0..4): cycles from curr_x/curr_y to valid colour input.
- XW, 11: width of curr_x and the horizontal counter.
- YW, 10: width of curr_y and the vertical counter.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: pixel clock.
- rst, in, 1: synchronous active-high reset.
- r_in, in, CW: red intensity.
- g_in, in, CW: green intensity.
- b_in, in, CW: blue intensity.
- curr_x, out, XW: visible column request, 0 outside active.
- curr_y, out, YW: visible row request, 0 outside active.
- req, out, 1: high when curr_x/curr_y address a visible pixel.
- pix_r, out, CW: red output.
- pix_g, out, CW: green output.
- pix_b, out, CW: blue output.
- hsync, out, 1: horizontal sync.
- vsync, out, 1: vertical sync.
- de, out, 1: display enable.
- line_start, out, 1: one-cycle pulse at the start of each line.
- frame_start, out, 1: one-cycle pulse at the start of each frame.
- testpat_en, in, 1: test-pattern select; present only with VGA_TESTPAT_EN.
REQ-003 One clock, clk; reset rst is synchronous, active-high.

Function
REQ-004 H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP shall be derived; the order within each line and frame shall be sync, back porch, active, front porch.
REQ-005 hcount shall count 0..H_TOTAL-1 and wrap to 0; vcount shall increment only on the hcount wrap, and shall wrap 0..V_TOTAL-1 in the same cycle that hcount wraps on line V_TOTAL-1.
REQ-006 Active region (counter stage): H_SYNC+H_BP <= hcount < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= vcount < V_SYNC+V_BP+V_ACTIVE.
REQ-007 Counter-stage outputs req, curr_x = hcount-(H_SYNC+H_BP) and curr_y = vcount-(V_SYNC+V_BP) shall be combinational from the counters; outside the active region req=0 and curr_x=curr_y=0.
REQ-008 r_in/g_in/b_in shall be sampled exactly PIPE_LAT cycles after the corresponding curr_x/curr_y and registered into pix_*; pix_* shall be 0 whenever the delayed de is 0.
REQ-009 Counter-stage sync (hcount<H_SYNC, vcount<V_SYNC), active, line_start (hcount==0) and frame_start (hcount==0 and vcount==0) shall pass through a PIPE_LAT+1 stage register delay line, so that hsync/vsync/de/line_start/frame_start align with pix_*.
REQ-010 hsync shall equal H_POL while delayed h-sync is true, else ~H_POL; vsync shall follow the same rule with V_POL.
REQ-011 Total output latency from counter state to pins shall be PIPE_LAT+1 cycles for every registered output.

Reset
REQ-012 While rst=1, hcount, vcount and all delay-line stages shall clear to 0/inactive; pix_*=0, de=0, line_start=0, frame_start=0, hsync=~H_POL, vsync=~V_POL.
REQ-013 In the first cycle after rst falls, hcount=0 and vcount=0; frame_start shall assert PIPE_LAT+1 cycles later.
REQ-014 Reset asserted mid-frame shall take effect on the next clk edge with no partial line completed.

Configuration
REQ-015 With macro VGA_TESTPAT_EN defined, port testpat_en shall exist; when it is 1, the colour sampled in REQ-008 shall be replaced by 8 equal-width vertical bars derived from delayed curr_x, bar k = {R=k[2], G=k[1], B=k[0]}, with each set bit giving all-ones CW.
REQ-016 Without VGA_TESTPAT_EN, the port and logic shall be absent and colour shall pass through unchanged.

Verification
REQ-017 Defaults, rst released, 1904x932x2 cycles -> hsync low for exactly 152 cycles per 1904; vsync low for exactly 3 lines per 932; frame_start once per 1774528 cycles.
REQ-018 Defaults, r_in=curr_x[3:0] -> at the first de cycle pix_r=0; at the last de cycle of the line pix_r=4'hF (x=1439); de high 1440 cycles per line on 900 lines.
REQ-019 PIPE_LAT=3, colour fed via a 3-stage register from curr_x -> pix_* matches curr_x delayed by 4 cycles; de rises 4 cycles after req.
REQ-020 rst pulsed at hcount=700, vcount=400 -> next cycle all outputs at reset values; counters restart at 0,0.
REQ-021 Wrap: at hcount=1903, vcount=931 -> next cycle both counters are 0; line_start and frame_start pulse together.
REQ-022 VGA_TESTPAT_EN defined, testpat_en=1 -> x=0..179 gives pix=000, x=180 gives pix_b=F, x=1260..1439 gives pix=FFF.
